// File: rtl/pcap_queue_dispatcher_if.sv
// Read-side FIFO handshake and shared per-queue output bus of the pcap replay queue dispatcher.
// master = dispatcher side, slave = FIFO / replay consumer side.
interface pcap_queue_dispatcher_if #(
   parameter int FIFO_DATA_WIDTH = 144,
   parameter int NUM_QUEUES      = 4,
   parameter int NUM_QUEUES_BITS = $clog2(NUM_QUEUES)
);
   logic [FIFO_DATA_WIDTH-1:0] fifo_dout;
   logic [NUM_QUEUES_BITS-1:0] fifo_dout_qid;
   logic                       fifo_empty;
   logic                       fifo_rd_en;
   logic [FIFO_DATA_WIDTH-1:0] m_data;
   logic [NUM_QUEUES-1:0]      m_valid;
   logic                       m_sop;
   logic                       m_eop;
   logic [NUM_QUEUES-1:0]      m_ready;

   modport master (
      input  fifo_dout, fifo_dout_qid, fifo_empty, m_ready,
      output fifo_rd_en, m_data, m_valid, m_sop, m_eop
   );

   modport slave (
      output fifo_dout, fifo_dout_qid, fifo_empty, m_ready,
      input  fifo_rd_en, m_data, m_valid, m_sop, m_eop
   );
endinterface

// File: rtl/pcap_queue_dispatcher.sv
// Parses packet headers off the packed replay FIFO and steers data words to one of
// NUM_QUEUES replay consumers; disabled queues and illegal lengths are drained and dropped.
//
//   state  | meaning
//   HDR_HI | waiting for / popping header word 0 (upper half of tuser beat, discarded)
//   HDR_LO | popping header word 1: latch length-derived word count and queue ID
//   DATA   | moving data words into the single-entry output register
//   DROP   | popping and discarding data words of a rejected packet
module pcap_queue_dispatcher #(
   parameter int FIFO_DATA_WIDTH = 144,
   parameter int WORDS_PER_BEAT  = 2,
   parameter int BEAT_BYTES      = 32,
   parameter int NUM_QUEUES      = 4,
   parameter int NUM_QUEUES_BITS = $clog2(NUM_QUEUES),
   parameter int MAX_PKT_LEN     = 1518
) (
   input  logic                      axi_aclk,
   input  logic                      axi_areset,
   pcap_queue_dispatcher_if.master   bus,
   input  logic [NUM_QUEUES-1:0]     q_enable,
   output logic [32*NUM_QUEUES-1:0]  pkt_cnt,
   output logic [31:0]               drop_cnt
);
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
   localparam int CNT_W      = 16;

   typedef enum logic [1:0] {HDR_HI, HDR_LO, DATA, DROP} state_t;
   state_t state, state_nxt;

   logic [CNT_W-1:0]           word_cnt;
   logic [NUM_QUEUES_BITS-1:0] pkt_qid;
   logic [NUM_QUEUES_BITS-1:0] out_qid;
   logic                       sop_flag;
   logic                       out_valid;
   logic                       out_sop;
   logic                       out_eop;
   logic [FIFO_DATA_WIDTH-1:0] out_data;

   logic                       rd_en;
   logic                       hdr_take;
   logic                       start_data;
   logic                       load;
   logic                       drop_inc;
   logic                       drain;
   logic                       cnt_zero;
   logic [15:0]                hdr_len;
   logic [16:0]                hdr_beats;
   logic [CNT_W-1:0]           hdr_last;

   // Length is split around the strobe bit of byte 0.
   assign hdr_len   = {bus.fifo_dout[16:9], bus.fifo_dout[7:0]};
   assign hdr_beats = ({1'b0, hdr_len} + 17'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
   assign hdr_last  = CNT_W'(32'(hdr_beats) * WORDS_PER_BEAT - 1);
   assign cnt_zero  = (word_cnt == '0);
   assign drain     = out_valid & bus.m_ready[out_qid];

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) state <= HDR_HI;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      rd_en      = 1'b0;
      hdr_take   = 1'b0;
      start_data = 1'b0;
      load       = 1'b0;
      drop_inc   = 1'b0;
      case (state)
         HDR_HI: begin
            if (!bus.fifo_empty) begin
               rd_en     = 1'b1;
               state_nxt = HDR_LO;
            end
         end
         HDR_LO: begin
            if (!bus.fifo_empty) begin
               rd_en    = 1'b1;
               hdr_take = 1'b1;
               if (hdr_len == '0) begin
                  drop_inc  = 1'b1;
                  state_nxt = HDR_HI;
               end else if (hdr_len > 16'(MAX_PKT_LEN) || !q_enable[bus.fifo_dout_qid]) begin
                  state_nxt = DROP;
               end else begin
                  start_data = 1'b1;
                  state_nxt  = DATA;
               end
            end
         end
         DATA: begin
            if (!bus.fifo_empty && (!out_valid || drain)) begin
               rd_en = 1'b1;
               load  = 1'b1;
               if (cnt_zero) state_nxt = HDR_HI;
            end
         end
         DROP: begin
            if (!bus.fifo_empty) begin
               rd_en = 1'b1;
               if (cnt_zero) begin
                  drop_inc  = 1'b1;
                  state_nxt = HDR_HI;
               end
            end
         end
         default: state_nxt = HDR_HI;
      endcase
   end

   // out_qid belongs to the word in the register; pkt_qid already tracks the next packet.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         word_cnt  <= '0;
         pkt_qid   <= '0;
         sop_flag  <= 1'b0;
         out_valid <= 1'b0;
         out_qid   <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_data  <= '0;
      end else begin
         if (hdr_take) begin
            pkt_qid  <= bus.fifo_dout_qid;
            word_cnt <= hdr_last;
         end
         if (start_data) sop_flag <= 1'b1;
         if (state == DROP && rd_en) word_cnt <= word_cnt - 1'b1;
         if (load) begin
            out_valid <= 1'b1;
            out_qid   <= pkt_qid;
            out_data  <= bus.fifo_dout;
            out_sop   <= sop_flag;
            out_eop   <= cnt_zero;
            sop_flag  <= 1'b0;
            word_cnt  <= word_cnt - 1'b1;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
         for (int q = 0; q < NUM_QUEUES; q++) begin
            if (drain && out_eop && out_qid == NUM_QUEUES_BITS'(q))
               pkt_cnt[32*q +: 32] <= pkt_cnt[32*q +: 32] + 32'd1;
         end
      end
   end

   assign bus.fifo_rd_en = rd_en & ~axi_areset;
   assign bus.m_data     = out_data;
   assign bus.m_sop      = out_sop & out_valid;
   assign bus.m_eop      = out_eop & out_valid;

   always_comb begin
      bus.m_valid = '0;
      if (out_valid) bus.m_valid[out_qid] = 1'b1;
   end
endmodule

// File: tb/tb_pcap_queue_dispatcher.sv
// Directed bench for pcap_queue_dispatcher: FWFT FIFO model, handshake monitor,
// and one task per scenario with hand-computed expectations.
module tb_pcap_queue_dispatcher;
   localparam int W = 144;

   logic         axi_aclk = 1'b0;
   logic         axi_areset;
   logic [3:0]   q_enable;
   logic [127:0] pkt_cnt;
   logic [31:0]  drop_cnt;
   int           checks;
   int           errors;

   pcap_queue_dispatcher_if #(.FIFO_DATA_WIDTH(W), .NUM_QUEUES(4), .NUM_QUEUES_BITS(2)) bus ();

   pcap_queue_dispatcher #(
      .FIFO_DATA_WIDTH(W), .WORDS_PER_BEAT(2), .BEAT_BYTES(32),
      .NUM_QUEUES(4), .NUM_QUEUES_BITS(2), .MAX_PKT_LEN(1518)
   ) dut (
      .axi_aclk  (axi_aclk),
      .axi_areset(axi_areset),
      .bus       (bus),
      .q_enable  (q_enable),
      .pkt_cnt   (pkt_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 axi_aclk = ~axi_aclk;

   // FWFT FIFO model: tasks append at wr_ptr, the model pops at rd_ptr.
   logic [W+1:0] mem [0:511];
   int           wr_ptr = 0;
   int           rd_ptr = 0;
   int           pops = 0;
   logic         pop_s = 1'b0;

   always @(posedge axi_aclk) begin
      #1;
      if (pop_s && axi_areset !== 1'b1 && rd_ptr < wr_ptr) begin
         rd_ptr++;
         pops++;
      end
      bus.fifo_empty = (rd_ptr >= wr_ptr);
      {bus.fifo_dout_qid, bus.fifo_dout} = (rd_ptr < wr_ptr) ? mem[rd_ptr] : '0;
   end

   typedef struct packed {
      logic [1:0]   qid;
      logic         sop;
      logic         eop;
      logic [W-1:0] d;
      int           cyc;
   } rx_t;

   rx_t rx_q[$];
   int  cyc = 0;
   int  valid_seen = 0;
   int  rd_when_empty = 0;
   int  bad_onehot = 0;

   always @(negedge axi_aclk) begin
      cyc++;
      pop_s = bus.fifo_rd_en;
      if (axi_areset !== 1'b1) begin
         if (bus.fifo_rd_en === 1'b1 && bus.fifo_empty === 1'b1) rd_when_empty++;
         if (bus.m_valid != 4'b0000) begin
            valid_seen++;
            if ($countones(bus.m_valid) > 1) bad_onehot++;
         end
         for (int q = 0; q < 4; q++)
            if (bus.m_valid[q] && bus.m_ready[q])
               rx_q.push_back({2'(q), bus.m_sop, bus.m_eop, bus.m_data, cyc});
      end
   end

   function automatic logic [W-1:0] mk_data(input logic [7:0] tag, input int idx);
      logic [7:0] ix;
      ix = 8'(idx);
      return {tag, ix, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};
   endfunction

   function automatic logic [W-1:0] mk_hdr(input logic [15:0] len);
      return {{7{16'hC3C3}}, 15'h1234, len[15:8], 1'b1, len[7:0]};
   endfunction

   task automatic tick();
      @(posedge axi_aclk);
      #2;
   endtask

   // Header word 0 and data words carry a wrong qid so only word 1's qid may be used.
   task automatic push_pkt(input int len, input logic [1:0] qid, input logic [7:0] tag, input int nwords);
      mem[wr_ptr] = {~qid, {9{16'h0F0F}}};
      wr_ptr++;
      mem[wr_ptr] = {qid, mk_hdr(16'(len))};
      wr_ptr++;
      for (int i = 0; i < nwords; i++) begin
         mem[wr_ptr] = {qid + 2'd1, mk_data(tag, i)};
         wr_ptr++;
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      tick();
      while (!(rd_ptr >= wr_ptr && bus.m_valid == 4'b0000) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout got %0d cycles exp below %0d", name, n, budget);
      end
      repeat (2) tick();
   endtask

   task automatic test_reset();
      axi_areset = 1'b1;
      mem[wr_ptr] = {2'd1, mk_hdr(16'd60)};
      wr_ptr++;
      repeat (2) tick();
      checks++;
      if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b exp 0", bus.fifo_rd_en); end
      checks++;
      if (bus.m_valid !== 4'b0000) begin errors++; $display("FAIL rst_m_valid got %b exp 0000", bus.m_valid); end
      checks++;
      if ({bus.m_sop, bus.m_eop} !== 2'b00) begin errors++; $display("FAIL rst_sop_eop got %b exp 00", {bus.m_sop, bus.m_eop}); end
      checks++;
      if (bus.m_data !== '0) begin errors++; $display("FAIL rst_m_data got %0h exp 0", bus.m_data); end
      checks++;
      if (pkt_cnt !== '0) begin errors++; $display("FAIL rst_pkt_cnt got %0h exp 0", pkt_cnt); end
      checks++;
      if (drop_cnt !== 32'd0) begin errors++; $display("FAIL rst_drop_cnt got %0d exp 0", drop_cnt); end
      wr_ptr = rd_ptr;
      repeat (2) tick();
      axi_areset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int p0, r0;
      p0 = pops;
      r0 = rx_q.size();
      q_enable = 4'b1111;
      bus.m_ready = 4'b1111;
      push_pkt(60, 2'd2, 8'h11, 4);
      wait_idle(60, "single");
      checks++;
      if (rx_q.size() - r0 != 4) begin errors++; $display("FAIL single_count got %0d exp 4", rx_q.size() - r0); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (r0 + i >= rx_q.size()) begin
            errors++; $display("FAIL single_word%0d got none exp word", i);
         end else if ({rx_q[r0+i].qid, rx_q[r0+i].sop, rx_q[r0+i].eop, rx_q[r0+i].d} !==
                      {2'd2, i == 0, i == 3, mk_data(8'h11, i)}) begin
            errors++;
            $display("FAIL single_word%0d got %0h exp %0h", i,
                     {rx_q[r0+i].qid, rx_q[r0+i].sop, rx_q[r0+i].eop, rx_q[r0+i].d},
                     {2'd2, i == 0, i == 3, mk_data(8'h11, i)});
         end
      end
      checks++;
      if (pkt_cnt[95:64] !== 32'd1) begin errors++; $display("FAIL single_pkt_cnt2 got %0d exp 1", pkt_cnt[95:64]); end
      checks++;
      if (pops - p0 != 6) begin errors++; $display("FAIL single_pops got %0d exp 6", pops - p0); end
      checks++;
      if (drop_cnt !== 32'd0) begin errors++; $display("FAIL single_drop_cnt got %0d exp 0", drop_cnt); end
   endtask

   task automatic test_back_to_back();
      int p0, r0, gap;
      logic [1:0] eq;
      logic [7:0] et;
      int         ei;
      p0 = pops;
      r0 = rx_q.size();
      push_pkt(64, 2'd0, 8'h21, 4);
      push_pkt(65, 2'd3, 8'h22, 6);
      wait_idle(80, "b2b");
      checks++;
      if (rx_q.size() - r0 != 10) begin errors++; $display("FAIL b2b_count got %0d exp 10", rx_q.size() - r0); end
      for (int i = 0; i < 10; i++) begin
         eq = (i < 4) ? 2'd0 : 2'd3;
         et = (i < 4) ? 8'h21 : 8'h22;
         ei = (i < 4) ? i : i - 4;
         checks++;
         if (r0 + i >= rx_q.size()) begin
            errors++; $display("FAIL b2b_word%0d got none exp word", i);
         end else begin
            if ({rx_q[r0+i].qid, rx_q[r0+i].sop, rx_q[r0+i].eop, rx_q[r0+i].d} !==
                {eq, i == 0 || i == 4, i == 3 || i == 9, mk_data(et, ei)}) begin
               errors++;
               $display("FAIL b2b_word%0d got %0h exp %0h", i,
                        {rx_q[r0+i].qid, rx_q[r0+i].sop, rx_q[r0+i].eop, rx_q[r0+i].d},
                        {eq, i == 0 || i == 4, i == 3 || i == 9, mk_data(et, ei)});
            end
            if (i > 0) begin
               gap = rx_q[r0+i].cyc - rx_q[r0+i-1].cyc;
               checks++;
               if (gap != ((i == 4) ? 3 : 1)) begin
                  errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, gap, (i == 4) ? 3 : 1);
               end
            end
         end
      end
      checks++;
      if ({pkt_cnt[127:96], pkt_cnt[31:0]} !== {32'd1, 32'd1}) begin
         errors++; $display("FAIL b2b_pkt_cnt got %0h exp 100000001", {pkt_cnt[127:96], pkt_cnt[31:0]});
      end
      checks++;
      if (pops - p0 != 14) begin errors++; $display("FAIL b2b_pops got %0d exp 14", pops - p0); end
   endtask

   task automatic test_drop_disabled();
      int p0, v0;
      p0 = pops;
      v0 = valid_seen;
      q_enable = 4'b1110;
      push_pkt(100, 2'd0, 8'h31, 8);
      wait_idle(60, "dis");
      checks++;
      if (pops - p0 != 10) begin errors++; $display("FAIL dis_pops got %0d exp 10", pops - p0); end
      checks++;
      if (valid_seen != v0) begin errors++; $display("FAIL dis_valid got %0d cycles exp 0", valid_seen - v0); end
      checks++;
      if (drop_cnt !== 32'd1) begin errors++; $display("FAIL dis_drop_cnt got %0d exp 1", drop_cnt); end
      checks++;
      if (pkt_cnt[31:0] !== 32'd1) begin errors++; $display("FAIL dis_pkt_cnt0 got %0d exp 1", pkt_cnt[31:0]); end
      q_enable = 4'b1111;
   endtask

   task automatic test_illegal_len();
      int p0, v0, r0;
      v0 = valid_seen;
      p0 = pops;
      push_pkt(0, 2'd1, 8'h41, 0);
      wait_idle(30, "len0");
      checks++;
      if (pops - p0 != 2) begin errors++; $display("FAIL len0_pops got %0d exp 2", pops - p0); end
      checks++;
      if (drop_cnt !== 32'd2) begin errors++; $display("FAIL len0_drop_cnt got %0d exp 2", drop_cnt); end
      p0 = pops;
      push_pkt(1600, 2'd1, 8'h42, 100);
      wait_idle(200, "len1600");
      checks++;
      if (pops - p0 != 102) begin errors++; $display("FAIL len1600_pops got %0d exp 102", pops - p0); end
      checks++;
      if (drop_cnt !== 32'd3) begin errors++; $display("FAIL len1600_drop_cnt got %0d exp 3", drop_cnt); end
      p0 = pops;
      push_pkt(1519, 2'd1, 8'h43, 96);
      wait_idle(200, "len1519");
      checks++;
      if (pops - p0 != 98) begin errors++; $display("FAIL len1519_pops got %0d exp 98", pops - p0); end
      checks++;
      if (drop_cnt !== 32'd4) begin errors++; $display("FAIL len1519_drop_cnt got %0d exp 4", drop_cnt); end
      checks++;
      if (valid_seen != v0) begin errors++; $display("FAIL illegal_valid got %0d cycles exp 0", valid_seen - v0); end
      p0 = pops;
      r0 = rx_q.size();
      push_pkt(1518, 2'd1, 8'h44, 96);
      wait_idle(200, "len1518");
      checks++;
      if (pops - p0 != 98) begin errors++; $display("FAIL len1518_pops got %0d exp 98", pops - p0); end
      checks++;
      if (rx_q.size() - r0 != 96) begin errors++; $display("FAIL len1518_count got %0d exp 96", rx_q.size() - r0); end
      checks++;
      if (rx_q.size() - r0 == 96 &&
          {rx_q[r0+95].qid, rx_q[r0+95].eop, rx_q[r0+95].d} !== {2'd1, 1'b1, mk_data(8'h44, 95)}) begin
         errors++; $display("FAIL len1518_last got %0h exp %0h",
                            {rx_q[r0+95].qid, rx_q[r0+95].eop, rx_q[r0+95].d}, {2'd1, 1'b1, mk_data(8'h44, 95)});
      end
      checks++;
      if (pkt_cnt[63:32] !== 32'd1) begin errors++; $display("FAIL len1518_pkt_cnt1 got %0d exp 1", pkt_cnt[63:32]); end
      checks++;
      if (drop_cnt !== 32'd4) begin errors++; $display("FAIL len1518_drop_cnt got %0d exp 4", drop_cnt); end
   endtask

   task automatic test_backpressure();
      int           r0, k, nstall;
      logic [W-1:0] held;
      logic         stalled, done, rdy1;
      r0 = rx_q.size();
      nstall = 0;
      stalled = 1'b0;
      done = 1'b0;
      k = 0;
      push_pkt(128, 2'd1, 8'h55, 8);
      while (k < 100 && !done) begin
         rdy1 = (k % 4 == 0) || (k % 4 == 3);
         bus.m_ready = {2'b00, rdy1, 1'b1};
         #2;
         if (stalled) begin
            checks++;
            if (bus.m_data !== held) begin errors++; $display("FAIL bp_hold%0d got %0h exp %0h", k, bus.m_data, held); end
         end
         stalled = bus.m_valid[1] && !bus.m_ready[1];
         if (stalled) begin
            nstall++;
            held = bus.m_data;
            checks++;
            if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_pop_full%0d got %b exp 0", k, bus.fifo_rd_en); end
         end
         done = (rx_q.size() - r0 == 8) && bus.m_valid == 4'b0000 && rd_ptr >= wr_ptr;
         tick();
         k++;
      end
      bus.m_ready = 4'b1111;
      repeat (2) tick();
      checks++;
      if (!done) begin errors++; $display("FAIL bp_timeout got %0d words exp 8", rx_q.size() - r0); end
      checks++;
      if (nstall == 0) begin errors++; $display("FAIL bp_stalls got 0 exp nonzero"); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (r0 + i >= rx_q.size()) begin
            errors++; $display("FAIL bp_word%0d got none exp word", i);
         end else if ({rx_q[r0+i].qid, rx_q[r0+i].sop, rx_q[r0+i].eop, rx_q[r0+i].d} !==
                      {2'd1, i == 0, i == 7, mk_data(8'h55, i)}) begin
            errors++;
            $display("FAIL bp_word%0d got %0h exp %0h", i,
                     {rx_q[r0+i].qid, rx_q[r0+i].sop, rx_q[r0+i].eop, rx_q[r0+i].d},
                     {2'd1, i == 0, i == 7, mk_data(8'h55, i)});
         end
      end
      checks++;
      if (pkt_cnt[63:32] !== 32'd2) begin errors++; $display("FAIL bp_pkt_cnt1 got %0d exp 2", pkt_cnt[63:32]); end
   endtask

   task automatic test_async_reset();
      int n, p0, r0;
      bus.m_ready = 4'b0000;
      push_pkt(200, 2'd2, 8'h66, 14);
      n = 0;
      while (bus.m_valid == 4'b0000 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (bus.m_valid !== 4'b0100) begin errors++; $display("FAIL ar_pre_valid got %b exp 0100", bus.m_valid); end
      @(negedge axi_aclk);
      #1;
      axi_areset = 1'b1;
      #1;
      checks++;
      if (bus.m_valid !== 4'b0000) begin errors++; $display("FAIL ar_m_valid got %b exp 0000", bus.m_valid); end
      checks++;
      if ({bus.m_sop, bus.m_eop, bus.fifo_rd_en} !== 3'b000) begin
         errors++; $display("FAIL ar_ctrl got %b exp 000", {bus.m_sop, bus.m_eop, bus.fifo_rd_en});
      end
      checks++;
      if (bus.m_data !== '0) begin errors++; $display("FAIL ar_m_data got %0h exp 0", bus.m_data); end
      wr_ptr = rd_ptr;
      repeat (3) tick();
      axi_areset = 1'b0;
      tick();
      checks++;
      if (pkt_cnt !== '0) begin errors++; $display("FAIL ar_pkt_cnt got %0h exp 0", pkt_cnt); end
      checks++;
      if (drop_cnt !== 32'd0) begin errors++; $display("FAIL ar_drop_cnt got %0d exp 0", drop_cnt); end
      bus.m_ready = 4'b1111;
      p0 = pops;
      r0 = rx_q.size();
      push_pkt(32, 2'd3, 8'h77, 2);
      wait_idle(40, "ar_post");
      checks++;
      if (rx_q.size() - r0 != 2) begin errors++; $display("FAIL ar_post_count got %0d exp 2", rx_q.size() - r0); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (r0 + i >= rx_q.size()) begin
            errors++; $display("FAIL ar_post_word%0d got none exp word", i);
         end else if ({rx_q[r0+i].qid, rx_q[r0+i].sop, rx_q[r0+i].eop, rx_q[r0+i].d} !==
                      {2'd3, i == 0, i == 1, mk_data(8'h77, i)}) begin
            errors++;
            $display("FAIL ar_post_word%0d got %0h exp %0h", i,
                     {rx_q[r0+i].qid, rx_q[r0+i].sop, rx_q[r0+i].eop, rx_q[r0+i].d},
                     {2'd3, i == 0, i == 1, mk_data(8'h77, i)});
         end
      end
      checks++;
      if (pkt_cnt !== {32'd1, 96'd0}) begin errors++; $display("FAIL ar_post_pkt_cnt got %0h exp %0h", pkt_cnt, {32'd1, 96'd0}); end
      checks++;
      if (pops - p0 != 4) begin errors++; $display("FAIL ar_post_pops got %0d exp 4", pops - p0); end
   endtask

   task automatic test_invariants();
      checks++;
      if (rd_when_empty != 0) begin errors++; $display("FAIL inv_rd_empty got %0d exp 0", rd_when_empty); end
      checks++;
      if (bad_onehot != 0) begin errors++; $display("FAIL inv_onehot got %0d exp 0", bad_onehot); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      axi_areset = 1'b1;
      q_enable = 4'b1111;
      bus.m_ready = 4'b1111;
      test_reset();
      test_single();
      test_back_to_back();
      test_drop_disabled();
      test_illegal_len();
      test_backpressure();
      test_async_reset();
      test_invariants();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end
endmodule
